// File: rtl/hm_wr_queue.sv
// hm_wr_queue: buffers single-DW host-memory write requests in a small FIFO
// and hands them one at a time to the write engine. A request that times out
// is re-issued up to MAX_RETRY times before it is dropped. Outcome counters
// are exported for software.
module hm_wr_queue #(
  parameter int DEPTH_LOG2 = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  trn_clk,
  input  logic                  trn_reset_n,
  input  logic                  trn_lnk_up_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [63:0]           req_addr,
  input  logic [31:0]           req_data,
  input  logic                  req_snoop,
  output logic                  tx_start,
  output logic [63:0]           hm_addr,
  output logic [31:0]           hm_data,
  output logic                  snoop,
  input  logic                  tx_end,
  input  logic                  timeout,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [31:0]           stat_wr_done,
  output logic [31:0]           stat_wr_abort,
  output logic [31:0]           stat_retry
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Retry counter needs to hold 0..MAX_RETRY; keep at least one bit.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [RW-1:0]         RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0]         RETRY_ONE = RW'(1);

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic        snp;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  req_t                  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  state_t                state_reg;
  state_t                state_next;
  logic [RW-1:0]         retry_cnt_reg;
  logic [63:0]           hm_addr_reg;
  logic [31:0]           hm_data_reg;
  logic                  snoop_reg;
  logic [31:0]           done_cnt_reg;
  logic [31:0]           abort_cnt_reg;
  logic [31:0]           retry_tot_reg;

  logic fifo_empty;
  logic push;
  logic pop;
  logic load;
  logic retry_inc;
  logic done_inc;
  logic abort_inc;

  assign fifo_empty    = (count_reg == '0);
  assign req_ready     = (count_reg != FULL_CNT);
  assign push          = req_valid && req_ready;
  assign fill_level    = count_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign hm_addr       = hm_addr_reg;
  assign hm_data       = hm_data_reg;
  assign snoop         = snoop_reg;
  assign stat_wr_done  = done_cnt_reg;
  assign stat_wr_abort = abort_cnt_reg;
  assign stat_retry    = retry_tot_reg;

  // Request storage; contents need no reset because count_reg qualifies them.
  always_ff @(posedge trn_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= '{addr: req_addr, data: req_data, snp: req_snoop};
    end
  end

  // FIFO pointers and occupancy; the head stays put until its request is finished.
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Dispatcher state register.
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Dispatcher next state and control strobes; tx_end takes priority over timeout.
  always_comb begin
    state_next = state_reg;
    tx_start   = 1'b0;
    pop        = 1'b0;
    load       = 1'b0;
    retry_inc  = 1'b0;
    done_inc   = 1'b0;
    abort_inc  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !trn_lnk_up_n) begin
          load       = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_start   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_end) begin
          pop        = 1'b1;
          done_inc   = 1'b1;
          state_next = ST_IDLE;
        end else if (timeout) begin
          if (retry_cnt_reg < RETRY_MAX) begin
            retry_inc  = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            pop        = 1'b1;
            abort_inc  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // In-flight request registers: loaded only when leaving IDLE so the engine
  // sees a stable address/data for the whole write, retries included.
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      hm_addr_reg   <= '0;
      hm_data_reg   <= '0;
      snoop_reg     <= 1'b0;
      retry_cnt_reg <= '0;
    end else begin
      if (load) begin
        hm_addr_reg   <= mem[rd_ptr_reg].addr;
        hm_data_reg   <= mem[rd_ptr_reg].data;
        snoop_reg     <= mem[rd_ptr_reg].snp;
        retry_cnt_reg <= '0;
      end else if (retry_inc) begin
        retry_cnt_reg <= retry_cnt_reg + RETRY_ONE;
      end
    end
  end

  // Outcome statistics, free-running and wrapping at 2^32.
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      done_cnt_reg  <= '0;
      abort_cnt_reg <= '0;
      retry_tot_reg <= '0;
    end else begin
      if (done_inc) begin
        done_cnt_reg <= done_cnt_reg + 32'd1;
      end
      if (abort_inc) begin
        abort_cnt_reg <= abort_cnt_reg + 32'd1;
      end
      if (retry_inc) begin
        retry_tot_reg <= retry_tot_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hm_wr_queue.sv
// Testbench for hm_wr_queue: table of single-request scenarios plus
// hand-written sequences for full FIFO, abort-then-next, spurious
// handshakes and asynchronous reset during a write.
module tb_hm_wr_queue;

  localparam int DEPTH_LOG2 = 2;
  localparam int MAX_RETRY  = 3;

  logic                trn_clk = 1'b0;
  logic                trn_reset_n = 1'b0;
  logic                trn_lnk_up_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [63:0]         req_addr = '0;
  logic [31:0]         req_data = '0;
  logic                req_snoop = 1'b0;
  logic                tx_start;
  logic [63:0]         hm_addr;
  logic [31:0]         hm_data;
  logic                snoop;
  logic                tx_end = 1'b0;
  logic                timeout = 1'b0;
  logic                busy;
  logic [DEPTH_LOG2:0] fill_level;
  logic [31:0]         stat_wr_done;
  logic [31:0]         stat_wr_abort;
  logic [31:0]         stat_retry;

  hm_wr_queue #(.DEPTH_LOG2(DEPTH_LOG2), .MAX_RETRY(MAX_RETRY)) dut (
    .trn_clk      (trn_clk),
    .trn_reset_n  (trn_reset_n),
    .trn_lnk_up_n (trn_lnk_up_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_snoop    (req_snoop),
    .tx_start     (tx_start),
    .hm_addr      (hm_addr),
    .hm_data      (hm_data),
    .snoop        (snoop),
    .tx_end       (tx_end),
    .timeout      (timeout),
    .busy         (busy),
    .fill_level   (fill_level),
    .stat_wr_done (stat_wr_done),
    .stat_wr_abort(stat_wr_abort),
    .stat_retry   (stat_retry)
  );

  always #5 trn_clk = ~trn_clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic        snp;
  } req_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic        snp;
    int          n_to;       // timeouts answered before the final response
    bit          both;       // final response drives tx_end and timeout together
    int          exp_pulses;
    int          exp_done;
    int          exp_abort;
    int          exp_retry;
  } vec_t;

  req_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulse_cnt = 0;

  // Count tx_start pulses as seen by the engine at each rising edge.
  always @(posedge trn_clk) begin
    if (tx_start === 1'b1) pulse_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge trn_clk);
  endtask

  task automatic push_req(input logic [63:0] a, input logic [31:0] d, input logic s,
                          input bit exp_acc);
    req_t r;
    check("req_ready_at_push", {63'd0, req_ready}, {63'd0, exp_acc});
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_snoop = s;
    if (exp_acc) begin
      r = '{a, d, s};
      exp_q.push_back(r);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic respond(input bit e, input bit t);
    tx_end  = e;
    timeout = t;
    step();
    tx_end  = 1'b0;
    timeout = 1'b0;
  endtask

  // Wait (bounded) for tx_start, then compare the presented request with the queue head.
  task automatic wait_start(input int max_cyc, output int cyc);
    cyc = 0;
    while (tx_start !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
    check("tx_start_seen", {63'd0, tx_start}, 64'd1);
    if (tx_start === 1'b1 && exp_q.size() > 0) begin
      check("hm_addr", hm_addr, exp_q[0].addr);
      check("hm_data", {32'd0, hm_data}, {32'd0, exp_q[0].data});
      check("snoop", {63'd0, snoop}, {63'd0, exp_q[0].snp});
    end
  endtask

  task automatic retire(input string how);
    req_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      $display("txn %s addr=0x%016h data=0x%08h snoop=%0d", how, r.addr, r.data, r.snp);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int   cyc;
    int   p0;
    logic [31:0] d0, a0, r0;
    req_t nr;

    vecs[0] = '{64'h0000_0000_1000_0004, 32'hDEADBEEF, 1'b1, 0, 1'b0, 1, 1, 0, 0};
    vecs[1] = '{64'h0000_0001_2345_6788, 32'h0BADF00D, 1'b0, 2, 1'b0, 3, 1, 0, 2};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h5555AAAA, 1'b1, 4, 1'b0, 4, 0, 1, 3};
    vecs[3] = '{64'h8000_0000_0000_0010, 32'h12345678, 1'b0, 0, 1'b1, 1, 1, 0, 0};
    vecs[4] = '{64'h0000_0000_0000_0020, 32'hCAFEF00D, 1'b1, 1, 1'b0, 2, 1, 0, 1};

    // Reset state
    repeat (3) step();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_tx_start", {63'd0, tx_start}, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_fill_level", {61'd0, fill_level}, 64'd0);
    check("rst_hm_addr", hm_addr, 64'd0);
    check("rst_stat_done", {32'd0, stat_wr_done}, 64'd0);
    trn_reset_n = 1'b1;
    step();

    // Table-driven single-request scenarios
    for (int i = 0; i < 5; i++) begin
      d0 = stat_wr_done;
      a0 = stat_wr_abort;
      r0 = stat_retry;
      p0 = pulse_cnt;
      push_req(vecs[i].addr, vecs[i].data, vecs[i].snp, 1'b1);
      wait_start(8, cyc);
      check("dispatch_latency", 64'(cyc), 64'd1);
      for (int t = 0; t < vecs[i].n_to; t++) begin
        step();
        step();
        check("busy_in_wait", {63'd0, busy}, 64'd1);
        respond(1'b0, 1'b1);
        if (t < MAX_RETRY) begin
          wait_start(0, cyc);
          check("retry_latency", 64'(cyc), 64'd0);
        end
      end
      if (vecs[i].n_to <= MAX_RETRY) begin
        repeat (6) step();
        respond(1'b1, vecs[i].both);
      end
      check("vec_pulses", 64'(pulse_cnt - p0), 64'(vecs[i].exp_pulses));
      check("vec_done", {32'd0, stat_wr_done - d0}, 64'(vecs[i].exp_done));
      check("vec_abort", {32'd0, stat_wr_abort - a0}, 64'(vecs[i].exp_abort));
      check("vec_retry", {32'd0, stat_retry - r0}, 64'(vecs[i].exp_retry));
      check("vec_fill_level", {61'd0, fill_level}, 64'd0);
      check("vec_busy", {63'd0, busy}, 64'd0);
      retire((vecs[i].n_to > MAX_RETRY) ? "abort" : "done");
    end

    // Full FIFO with link down, then drain in order with same-edge push/pop
    trn_lnk_up_n = 1'b1;
    p0 = pulse_cnt;
    d0 = stat_wr_done;
    for (int i = 0; i < 5; i++) begin
      push_req(64'h0000_00A0_0000_0000 + 64'(i * 16), 32'hA000_0000 + 32'(i), i[0], i < 4);
    end
    check("full_fill_level", {61'd0, fill_level}, 64'd4);
    check("full_req_ready", {63'd0, req_ready}, 64'd0);
    repeat (4) step();
    check("linkdown_no_start", 64'(pulse_cnt - p0), 64'd0);
    trn_lnk_up_n = 1'b0;
    wait_start(4, cyc);
    check("link_up_latency", 64'(cyc), 64'd1);
    for (int j = 0; j < 8 && exp_q.size() > 0; j++) begin
      if (j > 0) begin
        wait_start(4, cyc);
        check("b2b_gap", 64'(cyc), 64'd1);
      end
      step();
      step();
      if (j == 2) begin
        check("level_before_pushpop", {61'd0, fill_level}, 64'd2);
        nr = '{64'h0000_00B0_0000_0040, 32'hB00B_0001, 1'b1};
        exp_q.push_back(nr);
        req_valid = 1'b1;
        req_addr  = nr.addr;
        req_data  = nr.data;
        req_snoop = nr.snp;
      end
      respond(1'b1, 1'b0);
      req_valid = 1'b0;
      if (j == 2) begin
        check("level_after_pushpop", {61'd0, fill_level}, 64'd2);
      end
      retire("done");
    end
    check("drain_pulses", 64'(pulse_cnt - p0), 64'd5);
    check("drain_done", {32'd0, stat_wr_done - d0}, 64'd5);
    check("drain_empty", {61'd0, fill_level}, 64'd0);

    // Abort followed by dispatch of the next queued request
    a0 = stat_wr_abort;
    r0 = stat_retry;
    push_req(64'h0000_0000_0000_C000, 32'h0000_C0DE, 1'b0, 1'b1);
    push_req(64'h0000_0000_0000_D004, 32'h0000_D00D, 1'b1, 1'b1);
    wait_start(8, cyc);
    for (int t = 0; t <= MAX_RETRY; t++) begin
      step();
      respond(1'b0, 1'b1);
      if (t < MAX_RETRY) wait_start(0, cyc);
    end
    retire("abort");
    check("abort_count", {32'd0, stat_wr_abort - a0}, 64'd1);
    check("abort_retries", {32'd0, stat_retry - r0}, 64'd3);
    wait_start(4, cyc);
    check("after_abort_gap", 64'(cyc), 64'd1);
    step();
    respond(1'b1, 1'b0);
    retire("done");

    // Spurious handshakes in IDLE
    d0 = stat_wr_done;
    a0 = stat_wr_abort;
    r0 = stat_retry;
    p0 = pulse_cnt;
    respond(1'b1, 1'b0);
    respond(1'b0, 1'b1);
    respond(1'b1, 1'b1);
    check("spur_done", {32'd0, stat_wr_done}, {32'd0, d0});
    check("spur_abort", {32'd0, stat_wr_abort}, {32'd0, a0});
    check("spur_retry", {32'd0, stat_retry}, {32'd0, r0});
    check("spur_pulses", 64'(pulse_cnt - p0), 64'd0);
    check("spur_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of a write
    push_req(64'h0000_0000_0000_E008, 32'hEEEE_1111, 1'b1, 1'b1);
    push_req(64'h0000_0000_0000_F00C, 32'hFFFF_2222, 1'b1, 1'b1);
    wait_start(8, cyc);
    step();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2;
    trn_reset_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_tx_start", {63'd0, tx_start}, 64'd0);
    check("arst_hm_addr", hm_addr, 64'd0);
    check("arst_hm_data", {32'd0, hm_data}, 64'd0);
    check("arst_snoop", {63'd0, snoop}, 64'd0);
    check("arst_fill_level", {61'd0, fill_level}, 64'd0);
    check("arst_req_ready", {63'd0, req_ready}, 64'd1);
    check("arst_stat_done", {32'd0, stat_wr_done}, 64'd0);
    check("arst_stat_abort", {32'd0, stat_wr_abort}, 64'd0);
    check("arst_stat_retry", {32'd0, stat_retry}, 64'd0);
    step();
    trn_reset_n = 1'b1;
    exp_q.delete();
    p0 = pulse_cnt;
    repeat (5) step();
    check("post_rst_no_start", 64'(pulse_cnt - p0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hm_wr_queue.md
# hm_wr_queue

Request queue and dispatcher in front of the host-memory write engine. Buffers single-DW write requests (64-bit address, 32-bit data, snoop attribute) from the user side in a small FIFO. Issues them one at a time through the engine's `tx_start`/`tx_end`/`timeout` handshake, retrying timed-out writes a bounded number of times. Runs entirely in the TRN clock domain and exports per-outcome statistics counters.

## Interface
Parameters:
- `DEPTH_LOG2`, 2 — FIFO depth is 2^DEPTH_LOG2 entries.
- `MAX_RETRY`, 3 — re-issues allowed after a timeout before the request is aborted; 0 means no retry.

Ports:
- `trn_clk`  in  1  sole clock; everything is rising-edge.
- `trn_reset_n`  in  1  asynchronous, active-low reset.
- `trn_lnk_up_n`  in  1  link up when 0; gates new dispatches only.
- `req_valid`  in  1  a user write request is present.
- `req_ready`  out  1  FIFO can accept; equals `!full`, combinational from registered count.
- `req_addr`  in  64  target byte address; bits [1:0] are ignored downstream.
- `req_data`  in  32  write data.
- `req_snoop`  in  1  snoop attribute bit.
- `tx_start`  out  1  one-cycle start pulse to the write engine.
- `hm_addr`  out  64  registered address of the request in flight.
- `hm_data`  out  32  registered data of the request in flight.
- `snoop`  out  1  registered snoop bit of the request in flight.
- `tx_end`  in  1  one-cycle pulse: write completed.
- `timeout`  in  1  one-cycle pulse: write abandoned by the engine.
- `busy`  out  1  high in every state except IDLE.
- `fill_level`  out  DEPTH_LOG2+1  entries held, including the one in flight.
- `stat_wr_done`  out  32  completed writes.
- `stat_wr_abort`  out  32  requests dropped after exhausting retries.
- `stat_retry`  out  32  total re-issues.

## Operation
- FIFO:
  - Push on `req_valid && req_ready`.
  - Head is popped only on final completion or abort, never at issue.
  - Pointers wrap modulo depth; count saturates at 2^DEPTH_LOG2.
  - Push and pop on the same edge keeps the count unchanged.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If the FIFO is non-empty and `trn_lnk_up_n == 0`: load `hm_addr`/`hm_data`/`snoop` from the head, clear `retry_cnt`, go to ISSUE.
- ISSUE:
  - `tx_start = 1` for exactly this cycle.
  - Go to WAIT unconditionally.
- WAIT, on `tx_end`:
  - Pop head, increment `stat_wr_done`, go to IDLE.
- WAIT, on `timeout`:
  - If `retry_cnt < MAX_RETRY`: increment `retry_cnt` and `stat_retry`, go to ISSUE with the same registered request.
  - Otherwise: pop head, increment `stat_wr_abort`, go to IDLE.
- Simultaneous `tx_end` and `timeout` in WAIT: `tx_end` wins and counts as completion.
- `tx_end` or `timeout` outside WAIT: ignored and not counted.
- Link drop:
  - During WAIT: no effect; the engine's own timeout governs.
  - In IDLE: dispatch stalls and FIFO contents are retained.
- `hm_addr`/`hm_data`/`snoop` stay stable from the ISSUE cycle until the next IDLE→ISSUE load. The engine reads `hm_addr` combinationally while sending, so these registers must not change mid-write.
- Counters are 32-bit and wrap modulo 2^32.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; FIFO empty.
  - `tx_start`, `busy`, `snoop` = 0; `hm_addr`, `hm_data` = 0; `fill_level` = 0; all `stat_*` = 0.
  - `req_ready` = 1.
- Reset asserted mid-write abandons the request and the FIFO contents. Nothing is re-issued after reset.
- Dispatch latency: request accepted at edge k, FIFO previously empty, link up:
  - IDLE→ISSUE at edge k+1.
  - `tx_start` high between edges k+1 and k+2.
- Back-to-back: `tx_end` sampled at edge m → IDLE; ISSUE at m+1; next `tx_start` high between m+1 and m+2. This gap guarantees the engine is back in its idle state when the pulse arrives.
- Retry: `timeout` sampled at edge m → `tx_start` high between m and m+1.
- `fill_level` and `req_ready` update on the edge of the push or pop.

## Test plan
- Single write: push addr 0x0000_0000_1000_0004, data 0xDEADBEEF, snoop 1 with link up.
  - `tx_start` pulses exactly once, 2 edges after accept, with `hm_addr`/`hm_data`/`snoop` matching.
  - Model `tx_end` 6 cycles later → `stat_wr_done` = 1, `fill_level` = 0, `busy` = 0.
- Full FIFO with DEPTH_LOG2 = 2, link held down: push 5 requests back-to-back.
  - 4 accepted; `req_ready` = 0 after the 4th; `fill_level` = 4; no `tx_start`.
  - Raise link → 4 writes issued in push order, each `tx_start` one cycle after the preceding `tx_end` edge.
- Retry then success with MAX_RETRY = 3: answer `timeout`, `timeout`, then `tx_end`.
  - 3 `tx_start` pulses with an identical request; `stat_retry` = 2, `stat_wr_done` = 1, `stat_wr_abort` = 0.
- Abort with MAX_RETRY = 3: answer every pulse with `timeout`.
  - Exactly 4 `tx_start` pulses; `stat_retry` = 3, `stat_wr_abort` = 1.
  - Next queued request dispatched afterwards.
- Corner events:
  - `tx_end` and `timeout` on the same cycle → counted as done.
  - Spurious `tx_end` in IDLE → no counter change.
  - Push on the same edge as a pop while `fill_level` = 2 → level stays 2.
  - `trn_reset_n` pulled low during WAIT → all outputs at reset values immediately, without waiting for a clock edge.
